// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback SRAM slave: classic cycles, CTI/BTE bursts,
// programmable first-beat wait states, and ERR for addresses outside the window.
module wb_sram_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       WE,
  output logic                       ACK,
  output logic                       ERR
);
  localparam int NB  = WB_DATA_WIDTH / 8;
  localparam int LB  = $clog2(NB);
  localparam int WIN = MEM_ADDR_BITS + LB;

  typedef logic [WB_ADDR_WIDTH-1:0] adr_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                     state;
  logic [3:0]                 cnt;
  adr_t                       beat_adr;
  logic                       in_rng;
  adr_t                       nxt_adr;
  logic                       nxt_in;
  logic                       req;
  logic [WB_DATA_WIDTH-1:0]   mem [2**MEM_ADDR_BITS];

  // extra borrow bit tells us the address sits below the base
  function automatic logic in_win(input adr_t a);
    logic [WB_ADDR_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, BASE_ADDR};
    return !d[WB_ADDR_WIDTH] && ((d[WB_ADDR_WIDTH-1:0] >> WIN) == '0);
  endfunction

  function automatic logic [MEM_ADDR_BITS-1:0] widx(input adr_t a);
    adr_t off;
    off = a - BASE_ADDR;
    return MEM_ADDR_BITS'(off >> LB);
  endfunction

  assign req = CYC & STB;

  // predicted address of the following beat; wrap holds the upper word bits
  always_comb begin
    nxt_adr = beat_adr;
    if (CTI == 3'b010) begin
      case (BTE)
        2'b00:   nxt_adr = beat_adr + adr_t'(NB);
        2'b01:   nxt_adr[LB +: 2] = beat_adr[LB +: 2] + 2'd1;
        2'b10:   nxt_adr[LB +: 3] = beat_adr[LB +: 3] + 3'd1;
        default: nxt_adr[LB +: 4] = beat_adr[LB +: 4] + 4'd1;
      endcase
    end
    nxt_in = in_win(nxt_adr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      beat_adr <= '0;
      in_rng   <= 1'b0;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
      DAT_R    <= '0;
    end else begin
      ACK   <= 1'b0;
      ERR   <= 1'b0;
      DAT_R <= '0;
      case (state)
        S_IDLE: if (req) begin
          beat_adr <= ADR;
          in_rng   <= in_win(ADR);
          cnt      <= 4'(WAIT_STATES);
          state    <= (WAIT_STATES == 0) ? S_BURST : S_WAIT;
        end
        S_WAIT: begin
          if (!req) state <= S_IDLE;
          else if (cnt == 4'd0) begin
            ACK   <= in_rng;
            ERR   <= !in_rng;
            DAT_R <= (in_rng && !WE) ? mem[widx(beat_adr)] : '0;
            state <= S_BURST;
          end else cnt <= cnt - 4'd1;
        end
        S_BURST: begin
          if (!req) state <= S_IDLE;
          else if (!ACK && !ERR) begin
            // first beat with no wait states: response not yet issued
            ACK   <= in_rng;
            ERR   <= !in_rng;
            DAT_R <= (in_rng && !WE) ? mem[widx(beat_adr)] : '0;
          end else if (ACK && (CTI == 3'b001 || CTI == 3'b010)) begin
            beat_adr <= nxt_adr;
            in_rng   <= nxt_in;
            ACK      <= nxt_in;
            ERR      <= !nxt_in;
            DAT_R    <= (nxt_in && !WE) ? mem[widx(nxt_adr)] : '0;
          end else state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // a write lands only at the edge ending its ACK with the strobe still up
  always_ff @(posedge clk) begin
    if (state == S_BURST && ACK && req && WE)
      for (int b = 0; b < NB; b++)
        if (SEL[b]) mem[widx(beat_adr)][b*8 +: 8] <= DAT_W[b*8 +: 8];
  end
endmodule
